// File: rtl/bcd_display_scanner.sv
// Scans a sign + 3-digit BCD word onto a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking when LZ_BLANK_EN is defined.
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [12:0] bcdIn,
    input  logic        loadEn,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frameDone
);

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2,
        DIG_SIGN  = 2'd3
    } digit_e;

    localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]       SEG_MINUS  = 7'b0111111;

    logic [12:0]      data_q, data_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    digit_e           digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;
    logic             wrap;
    logic [6:0]       hunds_seg, tens_seg;

    function automatic logic [6:0] decode_nibble(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    always_comb begin
        data_d    = loadEn ? bcdIn : data_q;
        wrap      = (ref_cnt_q == REF_LAST);
        ref_cnt_d = wrap ? '0 : ref_cnt_q + CNT_W'(1);

        digit_d = digit_q;
        if (wrap) begin
            case (digit_q)
                DIG_ONES:  digit_d = DIG_TENS;
                DIG_TENS:  digit_d = DIG_HUNDS;
                DIG_HUNDS: digit_d = DIG_SIGN;
                default:   digit_d = DIG_ONES;
            endcase
        end

`ifdef LZ_BLANK_EN
        hunds_seg = (data_q[11:8] == 4'd0) ? SEG_BLANK : decode_nibble(data_q[11:8]);
        tens_seg  = (data_q[11:8] == 4'd0 && data_q[7:4] == 4'd0)
                    ? SEG_BLANK : decode_nibble(data_q[7:4]);
`else
        hunds_seg = decode_nibble(data_q[11:8]);
        tens_seg  = decode_nibble(data_q[7:4]);
`endif

        // Outputs follow the pre-edge digit index, so each digit is held exactly REFRESH_DIV cycles.
        an_d  = '1;
        seg_d = SEG_BLANK;
        case (digit_q)
            DIG_ONES: begin
                an_d  = 4'b1110;
                seg_d = decode_nibble(data_q[3:0]);
            end
            DIG_TENS: begin
                an_d  = 4'b1101;
                seg_d = tens_seg;
            end
            DIG_HUNDS: begin
                an_d  = 4'b1011;
                seg_d = hunds_seg;
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = data_q[12] ? SEG_MINUS : SEG_BLANK;
            end
        endcase

        frame_done_d = wrap && (digit_q == DIG_SIGN);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            data_q       <= '0;
            ref_cnt_q    <= '0;
            digit_q      <= DIG_ONES;
            seg_q        <= '1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            ref_cnt_q    <= ref_cnt_d;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with REFRESH_DIV=4; honours LZ_BLANK_EN if defined.
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        resetN;
    logic [12:0] bcdIn;
    logic        loadEn;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frameDone;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_ZERO  = 7'b1000000;
`ifdef LZ_BLANK_EN
    localparam logic [6:0] S_LZ    = 7'b1111111;
`else
    localparam logic [6:0] S_LZ    = 7'b1000000;
`endif

    bcd_display_scanner #(
        .REFRESH_DIV(4),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .bcdIn    (bcdIn),
        .loadEn   (loadEn),
        .seg      (seg),
        .an       (an),
        .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Expects to be called just before the first edge of a ones-digit period.
    task automatic check_frame(input string tag, input logic [6:0] s_ones, input logic [6:0] s_tens,
                               input logic [6:0] s_hunds, input logic [6:0] s_sign);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin exp_an = 4'b1110; exp_seg = s_ones;  end
                1:       begin exp_an = 4'b1101; exp_seg = s_tens;  end
                2:       begin exp_an = 4'b1011; exp_seg = s_hunds; end
                default: begin exp_an = 4'b0111; exp_seg = s_sign;  end
            endcase
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("%s_an_d%0d_c%0d", tag, d, c), {3'b0, an}, {3'b0, exp_an});
                check($sformatf("%s_seg_d%0d_c%0d", tag, d, c), seg, exp_seg);
                check($sformatf("%s_fd_d%0d_c%0d", tag, d, c), {6'b0, frameDone},
                      {6'b0, (d == 3 && c == 3)});
            end
        end
    endtask

    // Loads on the first edge of a frame, then idles to the next frame boundary.
    task automatic load_and_align(input logic [12:0] v);
        loadEn = 1'b1;
        bcdIn  = v;
        tick();
        loadEn = 1'b0;
        bcdIn  = '0;
        repeat (15) tick();
    endtask

    initial begin
        int pulses;
        int last;

        resetN = 1'b0;
        loadEn = 1'b0;
        bcdIn  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {3'b0, an}, 7'b0001111);
        check("rst_seg", seg, S_BLANK);
        check("rst_fd", {6'b0, frameDone}, 7'd0);

        @(negedge clk);
        resetN = 1'b1;
        check_frame("startup", S_ZERO, S_LZ, S_LZ, S_BLANK);

        load_and_align(13'h1128);
        check_frame("neg128", 7'b0000000, 7'b0100100, 7'b1111001, S_MINUS);

        load_and_align(13'h00B3);
        check_frame("badbcd", 7'b0110000, 7'b0000110, S_LZ, S_BLANK);

        load_and_align(13'h0007);
        check_frame("seven", 7'b1111000, S_LZ, S_LZ, S_BLANK);

        load_and_align(13'h1000);
        check_frame("negzero", S_ZERO, S_LZ, S_LZ, S_MINUS);

        load_and_align(13'h0967);
        check_frame("d967", 7'b1111000, 7'b0000010, 7'b0010000, S_BLANK);

        load_and_align(13'h0405);
        check_frame("d405", 7'b0010010, S_ZERO, 7'b0011001, S_BLANK);

        pulses = 0;
        last   = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frameDone) begin
                pulses++;
                if (last >= 0)
                    check("fd_spacing", 7'(i - last), 7'd16);
                last = i;
            end
        end
        check("fd_count", 7'(pulses), 7'd4);

        repeat (9) tick();
        check("pre_arst_an", {3'b0, an}, 7'b0001011);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_an", {3'b0, an}, 7'b0001111);
        check("arst_seg", seg, S_BLANK);
        check("arst_fd", {6'b0, frameDone}, 7'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        check_frame("post_arst", S_ZERO, S_LZ, S_LZ, S_BLANK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumes the 13-bit sign + 3-digit BCD word from the binary-to-BCD converter.
- Time-multiplexes that word onto a 4-digit common-anode 7-segment display: sign, hundreds, tens, ones.
- Snapshots its input on a load strobe so the display stays stable while upstream data changes.
- Is the last stage before the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is held active (legal range >= 1).
- CNT_W, 16, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- resetN  input  1  asynchronous active-low reset.
- bcdIn  input  13  [12] sign (1 = negative), [11:8] hundreds, [7:4] tens, [3:0] ones.
- loadEn  input  1  when high at a clk edge, bcdIn is captured into the data register.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anodes, active-low, registered; [0] ones, [1] tens, [2] hundreds, [3] sign.
- frameDone  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (asynchronous, resetN=0):
  - dataReg=0, refCnt=0, digitIdx=0.
  - an=4'b1111, seg=7'b1111111, frameDone=0.
  - All apply immediately, including mid-scan.
- dataReg loads bcdIn on any edge with loadEn=1.
  - The new value appears on seg/an at the next edge: 2 edges total from the loadEn edge.
  - loadEn held high reloads every cycle.
- refCnt counts 0..REFRESH_DIV-1 and wraps.
  - On the edge where refCnt==REFRESH_DIV-1, digitIdx advances 0->1->2->3->0.
  - With REFRESH_DIV=1, digitIdx advances every cycle.
- Output register, updated every edge from the current digitIdx and dataReg:
  - an = ~(4'b0001 << digitIdx).
  - seg is the decode of the selected nibble.
  - Consequence: each digit is shown for exactly REFRESH_DIV cycles; the first edge after reset release shows ones (an=4'b1110).
- frameDone = 1 for the single cycle following the edge on which digitIdx goes 3->0; 0 otherwise.
- Digit decode (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any nibble 10..15 = 'E' 0000110; no clamping or correction.
- Sign digit (idx 3): dataReg[12]=1 -> '-' 0111111; dataReg[12]=0 -> blank 1111111.
- loadEn coincident with a digit advance: both take effect; the new digit shows new data one edge later, with no mixed frame within a digit.

Optional Feature:
- LZ_BLANK_EN defined: leading-zero blanking.
  - Hundreds shows blank 1111111 when its nibble==0.
  - Tens shows blank when hundreds==0 and tens==0.
  - Ones is always shown.
  - Sign '-' is unaffected; -0 shows '-' in the sign position and '0' in ones.
- LZ_BLANK_EN undefined: all three numeric digits are always decoded, and zeros show as 1000000.

Test Plan (REFRESH_DIV=4):
- Reset/startup: hold resetN=0 -> an=1111, seg=1111111. Release -> first edge an=1110, seg=1000000 for 4 cycles.
- Scan order: load bcdIn=13'h1128 (-128) -> an sequence 1110/1101/1011/0111, each held 4 cycles, with seg 0000000 / 0100100 / 1111001 / 0111111.
- Frame pulse: free run 64 cycles -> frameDone high exactly 4 times, spaced 16 cycles, each 1 cycle wide.
- Invalid BCD: load 13'h00B3 -> tens digit seg=0000110 ('E'), ones seg=0110000, sign blank.
- LZ_BLANK_EN build: load 13'h0007 -> hundreds and tens 1111111, ones 1111000, sign 1111111. Non-LZ build: hundreds and tens 1000000.
- Async reset mid-scan: assert resetN=0 while an=1011 -> an=1111 and seg=1111111 without waiting for clk. After release, restart at ones with dataReg=0.
